// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: sends one byte to a 4-bit HD44780-style LCD as two E-strobed nibbles.
// Optional macro LCD_LONG_CMD_WAIT_EN stretches the post-byte wait for clear/home commands.
module lcd_nibble_writer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned GAP_CYC   = 50,
  parameter int unsigned WAIT_CYC  = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam int unsigned CW = 20;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SETUP_HI = 4'd1;
  localparam logic [3:0] S_PULSE_HI = 4'd2;
  localparam logic [3:0] S_HOLD_HI  = 4'd3;
  localparam logic [3:0] S_GAP      = 4'd4;
  localparam logic [3:0] S_SETUP_LO = 4'd5;
  localparam logic [3:0] S_PULSE_LO = 4'd6;
  localparam logic [3:0] S_HOLD_LO  = 4'd7;
  localparam logic [3:0] S_WAIT     = 4'd8;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);

  logic [3:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] wait_len;
  logic [7:0]    byte_q, byte_n;
  logic          rs_q, rs_n;

`ifdef LCD_LONG_CMD_WAIT_EN
  localparam int unsigned LONG_WAIT_CYC = 82000;
  assign wait_len = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ?
                    CW'(LONG_WAIT_CYC) : CW'(WAIT_CYC);
`else
  assign wait_len = CW'(WAIT_CYC);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    byte_n  = byte_q;
    rs_n    = rs_q;
    if (state == S_IDLE) begin
      if (iValid) begin
        state_n = S_SETUP_HI;
        cnt_n   = LD_SETUP;
        byte_n  = iData;
        rs_n    = iRS;
      end
    end else if (cnt != '0) begin
      cnt_n = cnt - CW'(1);
    end else begin
      case (state)
        S_SETUP_HI: begin state_n = S_PULSE_HI; cnt_n = LD_PULSE; end
        S_PULSE_HI: begin state_n = S_HOLD_HI;  cnt_n = LD_HOLD;  end
        S_HOLD_HI:  begin state_n = S_GAP;      cnt_n = LD_GAP;   end
        S_GAP:      begin state_n = S_SETUP_LO; cnt_n = LD_SETUP; end
        S_SETUP_LO: begin state_n = S_PULSE_LO; cnt_n = LD_PULSE; end
        S_PULSE_LO: begin state_n = S_HOLD_LO;  cnt_n = LD_HOLD;  end
        S_HOLD_LO:  begin state_n = S_WAIT;     cnt_n = wait_len - CW'(1); end
        default:    begin state_n = S_IDLE;     cnt_n = '0;       end
      endcase
    end
  end

  // LCD pins are registered from the next state so each pin changes only on a clock edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      byte_q              <= '0;
      rs_q                <= 1'b0;
      oDone               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      byte_q       <= byte_n;
      rs_q         <= rs_n;
      oDone        <= (state == S_WAIT) && (cnt == '0);
      oLCD_Enabled <= (state_n == S_PULSE_HI) || (state_n == S_PULSE_LO);
      oLCD_RegisterSelect <= (state_n != S_IDLE) && (state_n != S_WAIT) && rs_n;
      if (state_n inside {S_SETUP_HI, S_PULSE_HI, S_HOLD_HI, S_GAP})
        oLCD_Data <= byte_n[7:4];
      else if (state_n inside {S_SETUP_LO, S_PULSE_LO, S_HOLD_LO})
        oLCD_Data <= byte_n[3:0];
      else
        oLCD_Data <= '0;
    end
  end

  assign oReady                  = (state == S_IDLE);
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: doc/lcd_nibble_writer.md
LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, meaning cycles RS/data are stable before E rises (>=1).
REQ-002 SHALL have parameter PULSE_CYC, default 12, meaning cycles E is held high (>=1).
REQ-003 SHALL have parameter HOLD_CYC, default 1, meaning cycles data/RS are held after E falls (>=1).
REQ-004 SHALL have parameter GAP_CYC, default 50, meaning idle cycles between upper and lower nibble (>=1).
REQ-005 SHALL have parameter WAIT_CYC, default 2000, meaning post-byte execution wait in cycles (>=1).
REQ-006 SHALL have port Clock, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port iData, input, 8, byte to write to the LCD.
REQ-009 SHALL have port iRS, input, 1, register select for the byte: 0 command, 1 data.
REQ-010 SHALL have port iValid, input, 1, request to write iData/iRS.
REQ-011 SHALL have port oReady, output, 1, high only in IDLE; a byte is accepted when iValid and oReady are both high at a rising edge.
REQ-012 SHALL have port oDone, output, 1, one-cycle pulse when a byte's wait completes.
REQ-013 SHALL have port oLCD_Enabled, output, 1, LCD E strobe.
REQ-014 SHALL have port oLCD_RegisterSelect, output, 1, LCD RS.
REQ-015 SHALL have port oLCD_ReadWrite, output, 1, LCD R/W, constant 0.
REQ-016 SHALL have port oLCD_StrataFlashControl, output, 1, constant 1, keeping the shared StrataFlash bus disabled.
REQ-017 SHALL have port oLCD_Data, output, 4, LCD DB[7:4] nibble.

Function
REQ-018 SHALL implement states IDLE, SETUP_HI, PULSE_HI, HOLD_HI, GAP, SETUP_LO, PULSE_LO, HOLD_LO, WAIT.
REQ-019 SHALL latch iData and iRS on acceptance and ignore input changes until it returns to IDLE.
REQ-020 SHALL enter SETUP_HI on the edge after acceptance, driving oLCD_Data=iData[7:4] and RS=latched iRS.
REQ-021 SHALL remain SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC and WAIT_CYC cycles respectively in each like-named state, using a single down-counter of at least 20 bits reloaded on each state entry.
REQ-022 SHALL drive oLCD_Enabled high only in PULSE_HI and PULSE_LO.
REQ-023 SHALL drive oLCD_Data=latched[3:0] in SETUP_LO, PULSE_LO and HOLD_LO, and hold the upper nibble through HOLD_HI and GAP.
REQ-024 SHALL drive oLCD_Data=0 and RS=0 in IDLE and WAIT.
REQ-025 SHALL give an acceptance-to-oReady latency of exactly 2*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+GAP_CYC+WAIT_CYC cycles: 2080 at defaults.
REQ-026 SHALL pulse oDone on the last WAIT cycle, coincident with the transition back to IDLE.
REQ-027 SHALL ignore iValid while not in IDLE, without queueing; a request held high is accepted on the first IDLE cycle.
REQ-028 SHALL support back-to-back bytes: with iValid held, there are 0 idle cycles between oDone and the next acceptance edge.
REQ-029 SHALL register all LCD outputs so that they are glitch-free.

Reset
REQ-030 SHALL on Reset asynchronously force IDLE, counter=0, oLCD_Enabled=0, oLCD_Data=0, RS=0, oDone=0 and oReady=1 after release.
REQ-031 SHALL abort any byte in progress on mid-operation reset, dropping E within the same cycle, and SHALL NOT resume the byte.

Configuration
REQ-032 SHALL, when LCD_LONG_CMD_WAIT_EN is defined, use 82000 WAIT cycles for command bytes (RS=0) with value 0x01 or 0x02, and WAIT_CYC for all others.
REQ-033 SHALL, when LCD_LONG_CMD_WAIT_EN is undefined, use WAIT_CYC for every byte.

Verification
REQ-034 Bench SHALL reset mid-PULSE_HI: oLCD_Enabled goes 0 immediately; oReady=1 on the first edge after release; no lower nibble appears.
REQ-035 Bench SHALL write iData=0x48, iRS=1: E high for 12 cycles with Data=0x4, then 12 cycles with Data=0x8, RS=1 throughout; oDone after 2080 cycles.
REQ-036 Bench SHALL change iData to 0xFF in the cycle after accepting 0x28: the emitted nibbles remain 0x2 then 0x8.
REQ-037 Bench SHALL hold iValid with bytes 0x33 then 0x32: the second acceptance coincides with the oDone of the first, with exactly two E pulses per byte.
REQ-038 Bench SHALL, with LCD_LONG_CMD_WAIT_EN defined, write 0x01 at RS=0 -> 82080 cycles to oDone; 0x01 at RS=1 -> 2080 cycles; without the macro both -> 2080 cycles.
